// File: rtl/ups_pkg.sv
// rtl/ups_pkg.sv - shared constants and helpers for the bilinear quad upsampler
//
// Purpose: frame size codes, filter weights, sum width margin and the
//          size-code to frame-width decode used by upsample_bilinear_quad.
// Ports:   none (package).
package ups_pkg;

  localparam logic [2:0] SIZE_4X4   = 3'b000;
  localparam logic [2:0] SIZE_8X8   = 3'b001;
  localparam logic [2:0] SIZE_16X16 = 3'b010;
  localparam logic [2:0] SIZE_32X32 = 3'b011;
  localparam logic [2:0] SIZE_64X64 = 3'b100;

  localparam int W_NEAR = 9;
  localparam int W_ADJ  = 3;
  localparam int W_DIAG = 1;

  // Sums carry 5 guard bits over the pixel width (weights total 16).
  localparam int SUM_EXTRA = 5;
  localparam int SUM_W     = 16 + SUM_EXTRA;

  // Frame width in pixels; unknown codes collapse to a 1x1 frame.
  function automatic logic [7:0] ups_width(input logic [2:0] size);
    case (size)
      SIZE_4X4:   ups_width = 8'd4;
      SIZE_8X8:   ups_width = 8'd8;
      SIZE_16X16: ups_width = 8'd16;
      SIZE_32X32: ups_width = 8'd32;
      SIZE_64X64: ups_width = 8'd64;
      default:    ups_width = 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/ups_quad_fifo.sv
// rtl/ups_quad_fifo.sv - first-word-fall-through FIFO for output quads
//
// Purpose: holds finished quads (4 pixels + last flag) until the writer
//          takes them. Head entry is visible combinationally.
// Ports:   clk, rst (sync, active-low)
//          push, push_data  write side
//          pop              consume head (never issued while empty)
//          head_data        current head entry
//          count            occupancy 0..DEPTH
module ups_quad_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Push+pop together (even when full) leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/upsample_bilinear_quad.sv
// rtl/upsample_bilinear_quad.sv - 2x bilinear upsample of one 2x2 window into a 2x2 output quad
//
// Purpose: accepts 2x2 neighbourhoods, replicates frame edges, applies the
//          9/3/3/1 bilinear kernel in a 2-stage pipe and queues quads in a
//          credit-protected FWFT FIFO.
// Config:  UPS_ROUND_EN - when defined, +8 before >>>4 (round half up);
//          otherwise plain floor shift. Latency is identical.
// Ports:   clk, rst (sync, active-low)
//          size_upsample        frame size code, sampled on first beat of frame
//          win_valid/win_ready  window beat handshake
//          p_ul,p_ur,p_ll,p_lr  prev row col-1/col, cur row col-1/col
//          q00,q01,q10,q11      output quad (zero while out_valid is low)
//          out_valid/out_ready  quad handshake
//          out_last             quad from the last window of the frame
module upsample_bilinear_quad
  import ups_pkg::*;
#(
  parameter int LENGTH     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        size_upsample,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [LENGTH-1:0] p_ul,
  input  logic [LENGTH-1:0] p_ur,
  input  logic [LENGTH-1:0] p_ll,
  input  logic [LENGTH-1:0] p_lr,
  output logic [LENGTH-1:0] q00,
  output logic [LENGTH-1:0] q01,
  output logic [LENGTH-1:0] q10,
  output logic [LENGTH-1:0] q11,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int SW = LENGTH + SUM_EXTRA;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = 4 * LENGTH + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SUM_EXTRA + 1){1'b0}}, {(LENGTH - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SUM_EXTRA + 1){1'b1}}, {(LENGTH - 1){1'b0}}};
`ifdef UPS_ROUND_EN
  localparam logic signed [SW-1:0] RND_BIAS = SW'(8);
`else
  localparam logic signed [SW-1:0] RND_BIAS = '0;
`endif

  logic [7:0]    col, row, frame_w, cur_w;
  logic          first_beat, last_beat, accept;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          s1_valid, s1_last, s2_valid, s2_last;
  logic          pop;
  logic [QW-1:0] head;

  // Frame geometry: width comes straight from the size code on the first
  // beat and from the latched copy for the rest of the frame.
  assign first_beat = (col == 8'd0) && (row == 8'd0);
  assign cur_w      = first_beat ? ups_width(size_upsample) : frame_w;
  assign last_beat  = (col == cur_w - 8'd1) && (row == cur_w - 8'd1);

  // Credits: every beat in S1/S2 already owns a FIFO slot, so the FIFO
  // cannot overflow and the pipe never needs to stall.
  assign used      = {1'b0, fifo_count} + (CW + 1)'(s1_valid) + (CW + 1)'(s2_valid);
  assign win_ready = rst && (used < (CW + 1)'(FIFO_DEPTH));
  assign accept    = win_valid && win_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      col     <= 8'd0;
      row     <= 8'd0;
      frame_w <= 8'd1;
    end else if (accept) begin
      if (first_beat) frame_w <= cur_w;
      if (col == cur_w - 8'd1) begin
        col <= 8'd0;
        row <= last_beat ? 8'd0 : row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  // Edge replication: top row first, then left column on the result.
  logic [LENGTH-1:0] r_ul, r_ur, e_pix [4];
  logic signed [SW-1:0] ext [4];

  always_comb begin
    r_ul     = (row == 8'd0) ? p_ll : p_ul;
    r_ur     = (row == 8'd0) ? p_lr : p_ur;
    e_pix[0] = (col == 8'd0) ? r_ur : r_ul;
    e_pix[1] = r_ur;
    e_pix[2] = (col == 8'd0) ? p_lr : p_ll;
    e_pix[3] = p_lr;
    for (int k = 0; k < 4; k++) begin
      ext[k] = {{SUM_EXTRA{e_pix[k][LENGTH-1]}}, e_pix[k]};
    end
  end

  // S1: per-pixel weighted copies. Index 0..3 = ul, ur, ll, lr.
  logic signed [SW-1:0] s1_x9 [4], s1_x3 [4], s1_x1 [4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s1_x9[k] <= '0;
        s1_x3[k] <= '0;
        s1_x1[k] <= '0;
      end
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && last_beat;
      for (int k = 0; k < 4; k++) begin
        s1_x9[k] <= ext[k] * SW'(W_NEAR);
        s1_x3[k] <= ext[k] * SW'(W_ADJ);
        s1_x1[k] <= ext[k] * SW'(W_DIAG);
      end
    end
  end

  // S2: for output k the near pixel is k; the horizontal, vertical and
  // diagonal neighbours are k^1, k^2 and k^3 in the ul/ur/ll/lr indexing.
  logic signed [SW-1:0] sum [4], shv [4];
  logic [LENGTH-1:0]    sat [4];
  logic [LENGTH-1:0]    s2_q [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum[k] = s1_x9[k] + s1_x3[k ^ 1] + s1_x3[k ^ 2] + s1_x1[k ^ 3] + RND_BIAS;
      shv[k] = sum[k] >>> 4;
      if (shv[k] > SAT_MAX)      sat[k] = SAT_MAX[LENGTH-1:0];
      else if (shv[k] < SAT_MIN) sat[k] = SAT_MIN[LENGTH-1:0];
      else                       sat[k] = shv[k][LENGTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      for (int k = 0; k < 4; k++) s2_q[k] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      for (int k = 0; k < 4; k++) s2_q[k] <= sat[k];
    end
  end

  ups_quad_fifo #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s2_valid),
    .push_data ({s2_last, s2_q[3], s2_q[2], s2_q[1], s2_q[0]}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

  assign out_valid = rst && (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign q00       = out_valid ? head[LENGTH-1:0]            : '0;
  assign q01       = out_valid ? head[2*LENGTH-1:LENGTH]     : '0;
  assign q10       = out_valid ? head[3*LENGTH-1:2*LENGTH]   : '0;
  assign q11       = out_valid ? head[4*LENGTH-1:3*LENGTH]   : '0;
  assign out_last  = out_valid && head[QW-1];

endmodule

// File: tb/tb_upsample_bilinear_quad.sv
// tb/tb_upsample_bilinear_quad.sv - scoreboard testbench for upsample_bilinear_quad
module tb_upsample_bilinear_quad;

`ifdef UPS_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  typedef struct {
    int q00;
    int q01;
    int q10;
    int q11;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  size_upsample;
  logic        win_valid;
  logic        win_ready;
  logic [15:0] p_ul, p_ur, p_ll, p_lr;
  logic [15:0] q00, q01, q10, q11;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  upsample_bilinear_quad #(
    .LENGTH     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .size_upsample (size_upsample),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .p_ul          (p_ul),
    .p_ur          (p_ur),
    .p_ll          (p_ll),
    .p_lr          (p_lr),
    .q00           (q00),
    .q01           (q01),
    .q10           (q10),
    .q11           (q11),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last)
  );

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: compare every consumed quad against the scoreboard head.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL quad_unexpected: got q00=%0d last=%0b, required no quad", $signed(q00), out_last);
      end else begin
        mon_e = sb.pop_front();
        if ($signed(q00) != mon_e.q00 || $signed(q01) != mon_e.q01 ||
            $signed(q10) != mon_e.q10 || $signed(q11) != mon_e.q11 || out_last != mon_e.last) begin
          tests_failed++;
          $display("FAIL quad: got %0d %0d %0d %0d last=%0b, required %0d %0d %0d %0d last=%0b",
                   $signed(q00), $signed(q01), $signed(q10), $signed(q11), out_last,
                   mon_e.q00, mon_e.q01, mon_e.q10, mon_e.q11, mon_e.last);
        end
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ul, input int ur, input int ll, input int lr,
                      input int e00, input int e01, input int e10, input int e11, input bit el);
    exp_t e;
    int   waited;
    waited = 0;
    p_ul = 16'(ul); p_ur = 16'(ur); p_ll = 16'(ll); p_lr = 16'(lr);
    win_valid = 1'b1;
    @(negedge clk);
    while (!win_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!win_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      e.q00 = e00; e.q01 = e01; e.q10 = e10; e.q11 = e11; e.last = el;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    win_valid = 1'b0;
  endtask

  task automatic sendc(input int v, input bit el);
    send(v, v, v, v, v, v, v, v, el);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b0; size_upsample = 3'b000; win_valid = 1'b0; out_ready = 1'b0;
    p_ul = '0; p_ur = '0; p_ll = '0; p_lr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_win_ready", win_ready, 0);
    check("rst_q00", q00, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1x1 frames (illegal code) and N+3 latency.
    size_upsample = 3'b101;
    send(11, 22, 0, 80, 80, 80, 80, 80, 1);
    @(negedge clk); check("lat_n1", out_valid, 0);
    @(negedge clk); check("lat_n2", out_valid, 0);
    @(negedge clk); check("lat_n3", out_valid, 1);
    @(posedge clk); #1;
    send(0, 0, 0, -48, -48, -48, -48, -48, 1);
    out_ready = 1'b1;
    wait_drain("drain_1x1");

    // Constant 4x4 frame; size change mid-frame must be ignored.
    size_upsample = 3'b000;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) size_upsample = 3'b111;
      sendc(100, i == 15);
    end
    size_upsample = 3'b000;
    wait_drain("drain_const");

    // Edge, interior, rounding and extreme values inside one 4x4 frame.
    send(7, 9, 0, 160, 160, 160, 160, 160, 0);
    for (int i = 1; i < 5; i++) sendc(50, 0);
    send(0, 16, 32, 48, 12, 20, 28, 36, 0);
    send(1, 0, 0, 0, RND, 0, 0, 0, 0);
    sendc(32767, 0);
    sendc(-32768, 0);
    send(-1, 0, 0, 0, -1, RND ? 0 : -1, RND ? 0 : -1, RND ? 0 : -1, 0);
    for (int i = 10; i < 16; i++) sendc(25, i == 15);
    wait_drain("drain_mixed");

    // Backpressure: with the writer stalled only FIFO_DEPTH beats get in.
    out_ready = 1'b0;
    acc = 0;
    p_ul = 16'd1000; p_ur = 16'd1000; p_ll = 16'd1000; p_lr = 16'd1000;
    win_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (win_ready) begin
        mon_e.q00 = 1000 + acc; mon_e.q01 = 1000 + acc;
        mon_e.q10 = 1000 + acc; mon_e.q11 = 1000 + acc; mon_e.last = 1'b0;
        sb.push_back(mon_e);
        acc++;
      end
      @(posedge clk); #1;
      p_ul = 16'(1000 + acc); p_ur = 16'(1000 + acc);
      p_ll = 16'(1000 + acc); p_lr = 16'(1000 + acc);
    end
    win_valid = 1'b0;
    check("bp_accepted", acc, 4);
    @(negedge clk);
    check("bp_win_ready_low", win_ready, 0);
    check("bp_head_q00", $signed(q00), 1000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("drain_bp");

    // Mid-frame reset on an 8x8 frame.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    size_upsample = 3'b001;
    for (int i = 0; i < 20; i++) sendc(300, 0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid_a", out_valid, 0);
    check("midrst_win_ready", win_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_out_valid_b", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    size_upsample = 3'b000;
    send(5, 6, 0, 160, 160, 160, 160, 160, 0);
    for (int i = 1; i < 16; i++) sendc(9, i == 15);
    wait_drain("drain_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
